// File: rtl/sudoku_pkg.sv
// Shared scan-code constants, digit table and FSM state types for the
// PS/2 command front end of the sudoku engine.
package sudoku_pkg;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_ENTER = 8'h5A;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;

  // Set-2 make codes of the top-row digits 1..9, index 0 is digit 1
  localparam logic [7:0] DIGIT_SC [9] = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E,
                                          8'h36, 8'h3D, 8'h3E, 8'h46};

  typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {D_IDLE, D_EXT, D_BREAK, D_EXT_BREAK} dec_state_t;

  function automatic logic [3:0] digit_of(input logic [7:0] code);
    logic [3:0] d;
    d = 4'd0;
    for (int i = 0; i < 9; i++) begin
      if (code == DIGIT_SC[i]) d = 4'(i + 1);
    end
    return d;
  endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 frame receiver: input synchronizers, ps2_clk glitch filter,
// 11-bit frame FSM with parity/stop check and inter-edge timeout.
module ps2_rx
  import sudoku_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 200_000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       frame_error
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic          clk_s1, clk_s2, dat_s1, dat_s2;
  logic          clk_flt;
  logic [FW-1:0] flt_cnt;
  logic [TW-1:0] tmo_cnt;
  logic          mismatch, accept, fall, timeout;
  rx_state_t     state;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          parity_bit;

  assign mismatch = (clk_s2 != clk_flt);
  assign accept   = mismatch && (flt_cnt == FW'(FILTER_LEN - 1));
  assign fall     = accept && clk_flt;
  assign timeout  = (state != RX_IDLE) && (tmo_cnt == TW'(TIMEOUT_CYCLES));
  assign rx_byte  = shreg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clk_s1  <= 1'b1;
      clk_s2  <= 1'b1;
      dat_s1  <= 1'b1;
      dat_s2  <= 1'b1;
      clk_flt <= 1'b1;
      flt_cnt <= '0;
    end else begin
      clk_s1 <= ps2_clk;
      clk_s2 <= clk_s1;
      dat_s1 <= ps2_data;
      dat_s2 <= dat_s1;
      // The filtered level only moves after FILTER_LEN disagreeing samples in a row
      if (!mismatch) begin
        flt_cnt <= '0;
      end else if (accept) begin
        flt_cnt <= '0;
        clk_flt <= clk_s2;
      end else begin
        flt_cnt <= flt_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tmo_cnt <= '0;
    end else if (fall || state == RX_IDLE) begin
      tmo_cnt <= '0;
    end else if (tmo_cnt != TW'(TIMEOUT_CYCLES)) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= RX_IDLE;
      bit_cnt     <= '0;
      shreg       <= '0;
      parity_bit  <= 1'b0;
      byte_valid  <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      byte_valid  <= 1'b0;
      frame_error <= 1'b0;
      // A fall on the expiry cycle is still a live edge, so it takes priority
      if (fall) begin
        case (state)
          RX_IDLE: begin
            if (!dat_s2) begin
              state   <= RX_DATA;
              bit_cnt <= '0;
            end
          end
          RX_DATA: begin
            shreg   <= {dat_s2, shreg[7:1]};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd7) state <= RX_PARITY;
          end
          RX_PARITY: begin
            parity_bit <= dat_s2;
            state      <= RX_STOP;
          end
          RX_STOP: begin
            state <= RX_IDLE;
            if (dat_s2 && (^{shreg, parity_bit})) byte_valid  <= 1'b1;
            else                                  frame_error <= 1'b1;
          end
          default: state <= RX_IDLE;
        endcase
      end else if (timeout) begin
        state <= RX_IDLE;
      end
    end
  end

endmodule

// File: rtl/ps2_cmd_decoder.sv
// Turns PS/2 set-2 make/break sequences into one-cycle sudoku engine
// commands, suppressing typematic repeats and gating on engine_ready.
module ps2_cmd_decoder
  import sudoku_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 200_000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       engine_ready,
  output logic [3:0] cmd_number,
  output logic       cmd_up,
  output logic       cmd_down,
  output logic       cmd_left,
  output logic       cmd_right,
  output logic       cmd_enter,
  output logic       cmd_valid,
  output logic       frame_error
);

  logic [7:0] rx_byte;
  logic       byte_valid, rx_error;
  dec_state_t dec_state, dec_next;
  logic [8:0] last_make, key;
  logic       is_make, is_break, ext_bit, repeat_hit;
  logic [3:0] map_num;
  logic       map_up, map_down, map_left, map_right, map_enter, mapped;

  ps2_rx #(
    .FILTER_LEN     (FILTER_LEN),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_rx (
    .clk         (clk),
    .reset_n     (reset_n),
    .ps2_clk     (ps2_clk),
    .ps2_data    (ps2_data),
    .rx_byte     (rx_byte),
    .byte_valid  (byte_valid),
    .frame_error (rx_error)
  );

  assign frame_error = rx_error;

  always_comb begin
    is_make  = 1'b0;
    is_break = 1'b0;
    ext_bit  = 1'b0;
    dec_next = dec_state;
    case (dec_state)
      D_IDLE: begin
        if (rx_byte == SC_EXT)        dec_next = D_EXT;
        else if (rx_byte == SC_BREAK) dec_next = D_BREAK;
        else                          is_make  = 1'b1;
      end
      D_EXT: begin
        ext_bit = 1'b1;
        if (rx_byte == SC_BREAK) begin
          dec_next = D_EXT_BREAK;
        end else begin
          is_make  = 1'b1;
          dec_next = D_IDLE;
        end
      end
      D_BREAK: begin
        is_break = 1'b1;
        dec_next = D_IDLE;
      end
      default: begin
        ext_bit  = 1'b1;
        is_break = 1'b1;
        dec_next = D_IDLE;
      end
    endcase
  end

  assign key        = {ext_bit, rx_byte};
  assign repeat_hit = (key == last_make);
  assign map_num    = ext_bit ? 4'd0 : digit_of(rx_byte);
  assign map_enter  = !ext_bit && (rx_byte == SC_ENTER);
  assign map_up     = ext_bit && (rx_byte == SC_UP);
  assign map_down   = ext_bit && (rx_byte == SC_DOWN);
  assign map_left   = ext_bit && (rx_byte == SC_LEFT);
  assign map_right  = ext_bit && (rx_byte == SC_RIGHT);
  assign mapped     = (map_num != 4'd0) || map_enter || map_up || map_down || map_left || map_right;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dec_state  <= D_IDLE;
      last_make  <= '0;
      cmd_valid  <= 1'b0;
      cmd_number <= '0;
      cmd_up     <= 1'b0;
      cmd_down   <= 1'b0;
      cmd_left   <= 1'b0;
      cmd_right  <= 1'b0;
      cmd_enter  <= 1'b0;
    end else begin
      cmd_valid  <= 1'b0;
      cmd_number <= '0;
      cmd_up     <= 1'b0;
      cmd_down   <= 1'b0;
      cmd_left   <= 1'b0;
      cmd_right  <= 1'b0;
      cmd_enter  <= 1'b0;
      if (rx_error) begin
        dec_state <= D_IDLE;
      end else if (byte_valid) begin
        dec_state <= dec_next;
        // A held key resends its make code; only the first one counts
        if (is_make && !repeat_hit) begin
          last_make <= key;
          if (engine_ready && mapped) begin
            cmd_valid  <= 1'b1;
            cmd_number <= map_num;
            cmd_up     <= map_up;
            cmd_down   <= map_down;
            cmd_left   <= map_left;
            cmd_right  <= map_right;
            cmd_enter  <= map_enter;
          end
        end
        if (is_break && repeat_hit) last_make <= '0;
      end
    end
  end

endmodule

// File: tb/tb_ps2_cmd_decoder.sv
// Self-checking bench for ps2_cmd_decoder: PS/2 frame driver tasks, command
// scoreboard on the falling clock edge, scenario tasks and a final report.
module tb_ps2_cmd_decoder;

  localparam int FILTER_LEN  = 8;
  localparam int TIMEOUT     = 1000;
  localparam int HB          = 20;
  // raw stop-bit drop -> 2 sync flops -> FILTER_LEN filter samples -> byte_valid -> cmd_valid
  localparam int STOP_TO_CMD = 2 + FILTER_LEN + 1;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       engine_ready = 1'b0;
  logic [3:0] cmd_number;
  logic       cmd_up, cmd_down, cmd_left, cmd_right, cmd_enter, cmd_valid, frame_error;

  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;
  int          fe_seen = 0;
  int          cmd_seen = 0;
  int unsigned last_cmd_cyc = 0;
  int unsigned stop_drop_cyc = 0;
  logic [8:0]  exp_q[$];
  logic [8:0]  mon_got, mon_exp;

  ps2_cmd_decoder #(
    .FILTER_LEN     (FILTER_LEN),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .ps2_clk      (ps2_clk),
    .ps2_data     (ps2_data),
    .engine_ready (engine_ready),
    .cmd_number   (cmd_number),
    .cmd_up       (cmd_up),
    .cmd_down     (cmd_down),
    .cmd_left     (cmd_left),
    .cmd_right    (cmd_right),
    .cmd_enter    (cmd_enter),
    .cmd_valid    (cmd_valid),
    .frame_error  (frame_error)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [8:0] enc(input logic [3:0] num, input logic up, input logic dn,
                                     input logic lf, input logic rt, input logic en);
    return {num, up, dn, lf, rt, en};
  endfunction

  // scoreboard: every cmd_valid pops one expectation, idle cycles must be all zero
  always @(negedge clk) begin
    if (reset_n) begin
      mon_got = {cmd_number, cmd_up, cmd_down, cmd_left, cmd_right, cmd_enter};
      if (frame_error) fe_seen++;
      checks++;
      if (cmd_valid) begin
        cmd_seen++;
        last_cmd_cyc = cyc;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_cmd got=%h required=none", mon_got);
        end else begin
          mon_exp = exp_q.pop_front();
          if (mon_got !== mon_exp) begin
            errors++;
            $display("FAIL cmd_fields got=%h required=%h", mon_got, mon_exp);
          end
        end
      end else if (mon_got !== 9'd0) begin
        errors++;
        $display("FAIL idle_fields got=%h required=000", mon_got);
      end
    end
  end

  // driver tasks
  task automatic send_bit(input logic b, input logic is_stop);
    @(negedge clk);
    ps2_data = b;
    repeat (HB) @(negedge clk);
    ps2_clk = 1'b0;
    if (is_stop) stop_drop_cyc = cyc;
    repeat (HB) @(negedge clk);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_parity);
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i], 1'b0);
    send_bit((~^b) ^ bad_parity, 1'b0);
    send_bit(1'b1, 1'b1);
    repeat (2 * HB) @(negedge clk);
  endtask

  task automatic send_partial(input int nbits);
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < nbits; i++) send_bit(1'($urandom_range(0, 1)), 1'b0);
  endtask

  task automatic drain_and_check(input string name, input int c0, input int n_exp);
    repeat (4 * HB) @(negedge clk);
    checks++;
    if (cmd_seen - c0 != n_exp) begin
      errors++;
      $display("FAIL %s_count got=%0d required=%0d", name, cmd_seen - c0, n_exp);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_pending got=%0d required=0", name, exp_q.size());
    end
  endtask

  // scenarios
  task automatic test_reset();
    repeat (5) @(negedge clk);
    checks++;
    if ({cmd_valid, cmd_number, cmd_up, cmd_down, cmd_left, cmd_right, cmd_enter, frame_error} !== 11'd0) begin
      errors++;
      $display("FAIL reset_outputs got=%b required=0",
               {cmd_valid, cmd_number, cmd_up, cmd_down, cmd_left, cmd_right, cmd_enter, frame_error});
    end
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_number();
    int c0;
    c0 = cmd_seen;
    engine_ready = 1'b1;
    exp_q.push_back(enc(4'd5, 0, 0, 0, 0, 0));
    send_frame(8'h2E, 1'b0);
    checks++;
    if (last_cmd_cyc - stop_drop_cyc != STOP_TO_CMD) begin
      errors++;
      $display("FAIL stop_to_cmd_latency got=%0d required=%0d", last_cmd_cyc - stop_drop_cyc, STOP_TO_CMD);
    end
    send_frame(8'hF0, 1'b0);
    send_frame(8'h2E, 1'b0);
    drain_and_check("number", c0, 1);
  endtask

  task automatic test_extended();
    int c0;
    c0 = cmd_seen;
    exp_q.push_back(enc(4'd0, 1, 0, 0, 0, 0));
    send_frame(8'hE0, 1'b0);
    send_frame(8'h75, 1'b0);
    send_frame(8'hE0, 1'b0);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h75, 1'b0);
    exp_q.push_back(enc(4'd0, 0, 0, 1, 0, 0));
    send_frame(8'hE0, 1'b0);
    send_frame(8'h6B, 1'b0);
    drain_and_check("extended", c0, 2);
  endtask

  task automatic test_typematic();
    int c0;
    c0 = cmd_seen;
    exp_q.push_back(enc(4'd0, 0, 0, 0, 0, 1));
    repeat (3) send_frame(8'h5A, 1'b0);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h5A, 1'b0);
    exp_q.push_back(enc(4'd0, 0, 0, 0, 0, 1));
    send_frame(8'h5A, 1'b0);
    drain_and_check("typematic", c0, 2);
  endtask

  task automatic test_parity_error();
    int c0, f0;
    c0 = cmd_seen;
    f0 = fe_seen;
    send_frame(8'h16, 1'b1);
    checks++;
    if (fe_seen - f0 != 1) begin
      errors++;
      $display("FAIL frame_error_pulse got=%0d required=1", fe_seen - f0);
    end
    exp_q.push_back(enc(4'd1, 0, 0, 0, 0, 0));
    send_frame(8'h16, 1'b0);
    drain_and_check("parity", c0, 1);
  endtask

  task automatic test_not_ready();
    int c0;
    c0 = cmd_seen;
    engine_ready = 1'b0;
    send_frame(8'h3D, 1'b0);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h3D, 1'b0);
    engine_ready = 1'b1;
    exp_q.push_back(enc(4'd7, 0, 0, 0, 0, 0));
    send_frame(8'h3D, 1'b0);
    drain_and_check("not_ready", c0, 1);
  endtask

  task automatic test_timeout();
    int c0;
    c0 = cmd_seen;
    send_partial(4);
    repeat (TIMEOUT + 500) @(negedge clk);
    exp_q.push_back(enc(4'd9, 0, 0, 0, 0, 0));
    send_frame(8'h46, 1'b0);
    drain_and_check("timeout", c0, 1);
  endtask

  task automatic test_reset_mid_frame();
    int c0;
    c0 = cmd_seen;
    send_partial(3);
    @(negedge clk);
    ps2_clk = 1'b0;
    repeat (HB / 2) @(negedge clk);
    reset_n = 1'b0;
    #1;
    checks++;
    if ({cmd_valid, cmd_number, cmd_up, cmd_down, cmd_left, cmd_right, cmd_enter, frame_error} !== 11'd0) begin
      errors++;
      $display("FAIL midframe_reset_outputs got=%b required=0",
               {cmd_valid, cmd_number, cmd_up, cmd_down, cmd_left, cmd_right, cmd_enter, frame_error});
    end
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    repeat (5) @(negedge clk);
    reset_n = 1'b1;
    repeat (2 * HB) @(negedge clk);
    // last_make was cleared by reset, so the previously held 46 is a fresh make
    exp_q.push_back(enc(4'd9, 0, 0, 0, 0, 0));
    send_frame(8'h46, 1'b0);
    drain_and_check("reset_mid", c0, 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_number();
    test_extended();
    test_typematic();
    test_parity_error();
    test_not_ready();
    test_timeout();
    test_reset_mid_frame();
    checks++;
    if (fe_seen != 1) begin
      errors++;
      $display("FAIL frame_error_total got=%0d required=1", fe_seen);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ps2_cmd_decoder.md
Name: ps2_cmd_decoder

Overview:
Upstream command source for sudoku_engine. Receives PS/2 keyboard frames and decodes make/break scan codes into one-cycle command pulses: cmd_number, cmd_up/down/left/right, cmd_enter and cmd_valid. These feed the engine command inputs directly. Held-key typematic repeats are suppressed, and commands are dropped while the engine is loading or checking.

Parameters:
FILTER_LEN, 8, consecutive equal synchronized samples of ps2_clk required before a level change is accepted
TIMEOUT_CYCLES, 200_000, max clk cycles between accepted ps2_clk falling edges inside a frame before abort

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
ps2_clk  in  1  raw PS/2 clock, asynchronous
ps2_data  in  1  raw PS/2 data, asynchronous
engine_ready  in  1  high when sudoku_engine is in S_PLAY
cmd_number  out  4  digit 1..9 on a number command, else 0
cmd_up  out  1  up-arrow command
cmd_down  out  1  down-arrow command
cmd_left  out  1  left-arrow command
cmd_right  out  1  right-arrow command
cmd_enter  out  1  Enter command
cmd_valid  out  1  one-cycle strobe qualifying all cmd_* fields
frame_error  out  1  one-cycle pulse on a parity or stop-bit error

Behaviour:
- Reset: one clock, clk. Reset is asynchronous and active-low on reset_n. While reset_n is low:
  - all outputs are 0;
  - both FSMs are in idle;
  - filters are cleared to 1 (bus idle);
  - last_make is cleared to 0x00.
- Input conditioning:
  - ps2_clk and ps2_data each pass through a 2-flop synchronizer.
  - ps2_clk then passes through a FILTER_LEN saturating filter.
  - An accepted 1->0 transition of the filtered clock is a "fall" event. ps2_data is sampled on the fall event.
- Receiver FSM (RX_IDLE, RX_DATA, RX_PARITY, RX_STOP):
  - RX_IDLE: a fall with data=0 (start bit) goes to RX_DATA and clears the bit count. A fall with data=1 is ignored.
  - RX_DATA: 8 falls shift data in LSB first, then go to RX_PARITY.
  - RX_PARITY: sample the parity bit, go to RX_STOP.
  - RX_STOP: sample the stop bit, go to RX_IDLE. The byte is good if the 9 bits (data plus parity) have odd parity and stop=1.
    - Good byte: byte_valid pulses the cycle after the stop fall.
    - Bad byte: frame_error pulses on that same cycle instead, the byte is discarded, and the decoder returns to D_IDLE.
  - Timeout: a counter resets on every fall. If it reaches TIMEOUT_CYCLES in any state other than RX_IDLE, the FSM returns to RX_IDLE. No error pulse, no byte.
- Decoder FSM (D_IDLE, D_EXT, D_BREAK, D_EXT_BREAK). It acts only on byte_valid.
  - D_IDLE:
    - E0 -> D_EXT
    - F0 -> D_BREAK
    - other byte -> make(code, ext=0)
  - D_EXT:
    - F0 -> D_EXT_BREAK
    - other byte -> make(code, ext=1), then D_IDLE
  - D_BREAK / D_EXT_BREAK:
    - any byte -> break(code, ext), then D_IDLE
- make(code, ext):
  - If {ext,code} equals last_make, it is a typematic repeat and is ignored.
  - Otherwise last_make <= {ext,code} and the mapping lookup runs.
- break(code, ext): if {ext,code} equals last_make, last_make is cleared to 0x00.
- Mapping, non-extended:
  - 16/1E/26/25/2E/36/3D/3E/46 -> cmd_number 1..9
  - 5A -> cmd_enter
- Mapping, extended:
  - E0 75 -> cmd_up
  - E0 72 -> cmd_down
  - E0 6B -> cmd_left
  - E0 74 -> cmd_right
- Unmapped codes produce no command but still update last_make.
- Command output timing:
  - A mapped make asserts cmd_valid plus exactly one command field for exactly one clk, on the cycle after byte_valid. Stop fall to cmd_valid is 2 cycles.
  - All cmd_* are 0 on every other cycle.
  - If engine_ready=0 on the byte_valid cycle, the command is dropped. No pulse is issued and no queueing occurs, but last_make still updates.
- Simultaneous fall and timeout expiry on the same cycle: the fall wins.
- A reset_n assertion mid-frame aborts the frame. No partial output is produced.

Decomposition:
- Shared package sudoku_pkg holds:
  - scan-code constants (SC_EXT=E0, SC_BREAK=F0, SC_ENTER, SC_UP, SC_DOWN, SC_LEFT, SC_RIGHT);
  - a 9-entry digit scan-code table;
  - the rx_state_t and dec_state_t enums.
- Sub-module ps2_rx contains the synchronizers, the filter, the receiver FSM and the timeout. It outputs rx_byte[7:0], byte_valid and frame_error.
- The top level holds the decoder FSM, last_make and the command register.

Test Plan:
- engine_ready=1, frame 2E then F0 2E -> one cmd_valid pulse with cmd_number=4'd5 exactly 2 clk after the stop fall; the break produces nothing.
- E0 75, then E0 F0 75, then E0 6B -> cmd_up pulse, nothing for the break, then a cmd_left pulse; all other fields 0.
- 5A sent three times (typematic), then F0 5A, then 5A -> exactly two cmd_enter pulses in total (the first and the last).
- Frame 16 with inverted parity -> frame_error pulses for 1 clk with no cmd_valid; a following good frame 16 -> cmd_number=1.
- engine_ready=0 during 3D -> no pulse; after F0 3D, raise engine_ready and send 3D -> cmd_number=7.
- Send start bit plus 4 data bits, stall longer than TIMEOUT_CYCLES, then a full frame 46 -> single cmd_number=9; reset_n pulsed mid-frame -> all outputs 0 immediately.
